frm_parser: RTL and testbench
=============================

// Module: frm_parser
// PURPOSE
//  Reader-side parser for the tag backscatter frame. Consumes the decoded bit stream (one bit per
//  clk_frm with rx_valid), locks onto the FM0 or Miller preamble selected by m/trext, and extracts
//  data_len reply bits. When en_crc16_for_rpy=1 it checks the trailing CRC-16, then checks the
//  end-of-signalling '1'. Serves as the loopback checker and reader model behind the tag encoders.
// PARAMETERS
//  MAX_HUNT  64  rx_valid bits allowed in HUNT before the preamble search is abandoned
//  DLEN_W    8   width of data_len
// PORTS
//  clk_frm              in   1       frame bit clock
//  rst_for_new_package  in   1       asynchronous, active-low reset; clears the parser for a new frame
//  rx_bit               in   1       decoded serial bit
//  rx_valid             in   1       rx_bit is valid this cycle; all state advances only when high
//  m                    in   2       00=FM0, 01/10/11=Miller M=2/4/8
//  trext                in   1       1 = extended pilot preamble
//  en_crc16_for_rpy     in   1       1 = 16 CRC bits follow the data, MSB first
//  data_len             in   DLEN_W  number of reply data bits, excluding CRC; 0 is legal
//  preamble_found       out  1       one-cycle pulse when the preamble has matched
//  data_bit             out  1       extracted data bit
//  data_valid           out  1       one-cycle strobe qualifying data_bit
//  frm_complete         out  1       sticky; frame ended (good or bad)
//  crc_ok / crc_err     out  1       sticky CRC verdict; both stay 0 when CRC is disabled
//  eos_err              out  1       sticky; end-of-signalling bit was 0
//  hunt_timeout         out  1       sticky; no preamble within MAX_HUNT bits
//  busy                 out  1       high in every state except DONE
// BEHAVIOUR
//  Reset: all outputs 0; state=HUNT; 22-bit shift register=0; CRC register=16'hFFFF; counters=0.
//  m, trext, en_crc16_for_rpy and data_len are latched on the first rx_valid after reset and held
//  for the rest of the frame.
//  Preamble, in bits oldest first; the match requires exactly the last L received bits:
//   FM0, trext=0:    101001                   L=6
//   FM0, trext=1:    12 x '0' then 101001     L=18
//   Miller, trext=0: 0000 010111              L=10
//   Miller, trext=1: 16 x '0' then 010111     L=22
//  FSM:
//   HUNT  Shift rx_bit into the register on each rx_valid. On a match: pulse preamble_found the
//         next cycle and go to DATA. If data_len=0, go directly to CRC (en_crc16_for_rpy=1) or EOS.
//         MAX_HUNT bits without a match: set hunt_timeout and frm_complete, go to DONE.
//   DATA  Each rx_valid: data_bit<=rx_bit and data_valid<=1, both registered (1-cycle latency).
//         Feed the bit to the CRC. After data_len bits go to CRC (en_crc16_for_rpy=1), else EOS.
//   CRC   Receive 16 bits and feed each to the CRC. data_valid stays 0. Then go to EOS.
//   EOS   One rx_valid bit. If it is 0, set eos_err. Set frm_complete; if CRC is enabled, also set
//         crc_ok (residue==16'h1D0F) or crc_err (any other value). Go to DONE.
//   DONE  Hold all sticky flags. Ignore input until reset.
//  CRC-16: polynomial x^16+x^12+x^5+1 (0x1021), preset FFFF, MSB-first serial update:
//   fb=crc[15]^bit; crc<={crc[14:0],1'b0}^(fb?16'h1021:0).
//  The tag transmits the ones-complement CRC, so a good frame leaves residue 16'h1D0F.
//  rx_valid=0 in any state: no state, counter, CRC or output change, except that pulses clear.
//  Reset asserted mid-frame: asynchronous return to the reset values; the next frame needs no gap.
//  The bit counter is wide enough for data_len max + 16, so it cannot wrap.
// TESTING
//  1 FM0, trext=0, CRC off, len=8: 101001,A5,1 -> preamble_found 1 clk after the 6th bit;
//    data bits 1,0,1,0,0,1,0,1; frm_complete=1; crc_ok=crc_err=eos_err=0.
//  2 M=4, trext=1, CRC on, len=72: 16 zeros,010111,ASCII "123456789",16'hD64E,1
//    -> 72 data_valid strobes, crc_ok=1, crc_err=0.
//  3 Same as test 2 with data bit 5 flipped -> crc_err=1, crc_ok=0, frm_complete=1.
//  4 FM0, trext=0, len=4: 101001,1100,0 -> eos_err=1, frm_complete=1.
//  5 64 bits of 1010... with no preamble -> hunt_timeout=1, frm_complete=1, busy=0, no data_valid.
//  6 Reset pulsed after 3 data bits, then a full frame as in test 1 -> no stale flags;
//    exactly 8 fresh data_valid strobes. Also insert rx_valid=0 gaps -> identical results.

Source files
------------

// File: rtl/frm_if.sv
// Bus between the bit-stream source and the frame parser.
// Handshake: a bit transfers on every clk_frm edge where rx_valid is high; the parser has no
// back-pressure (no ready), so the source must present one decoded bit per rx_valid cycle.
// Configuration inputs are sampled together with the first rx_valid bit after reset.
interface frm_if #(
    parameter int DLEN_W = 8
);
    logic              rx_bit;
    logic              rx_valid;
    logic [1:0]        m;
    logic              trext;
    logic              en_crc16_for_rpy;
    logic [DLEN_W-1:0] data_len;
    logic              preamble_found;
    logic              data_bit;
    logic              data_valid;
    logic              frm_complete;
    logic              crc_ok;
    logic              crc_err;
    logic              eos_err;
    logic              hunt_timeout;
    logic              busy;

    // Bit-stream source / reader side
    modport master (
        output rx_bit, rx_valid, m, trext, en_crc16_for_rpy, data_len,
        input  preamble_found, data_bit, data_valid, frm_complete,
               crc_ok, crc_err, eos_err, hunt_timeout, busy
    );

    // Frame parser side
    modport slave (
        input  rx_bit, rx_valid, m, trext, en_crc16_for_rpy, data_len,
        output preamble_found, data_bit, data_valid, frm_complete,
               crc_ok, crc_err, eos_err, hunt_timeout, busy
    );
endinterface

// File: rtl/frm_parser.sv
// Reader-side parser for tag backscatter frames: hunts for the FM0/Miller preamble, extracts
// data_len reply bits, optionally checks the CRC-16 residue, then checks the end-of-signalling bit.
// state_o exposes the FSM state for debug (HUNT=0, DATA=1, CRC=2, EOS=3, DONE=4).
module frm_parser #(
    parameter int MAX_HUNT = 64,
    parameter int DLEN_W   = 8
) (
    input  logic       clk_frm,
    input  logic       rst_for_new_package,
    frm_if.slave       bus,
    output logic [2:0] state_o
);
    localparam int HUNT_W = $clog2(MAX_HUNT + 1);
    localparam int CNT_W  = DLEN_W + 1;

    typedef enum logic [2:0] {S_HUNT, S_DATA, S_CRC, S_EOS, S_DONE} state_t;

    state_t             state_q;
    // Holds the 21 previous bits; together with the incoming bit it forms the 22-bit window.
    logic [20:0]        sr_q;
    logic [15:0]        crc_q;
    logic [HUNT_W-1:0]  hunt_cnt_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               cfg_vld_q;
    logic [1:0]         m_q;
    logic               trext_q;
    logic               crc_en_q;
    logic [DLEN_W-1:0]  len_q;
    logic               preamble_found_q, data_bit_q, data_valid_q, frm_complete_q;
    logic               crc_ok_q, crc_err_q, eos_err_q, hunt_timeout_q, busy_q;

    logic [21:0]        sr_d;
    logic [15:0]        crc_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [1:0]         m_e;
    logic               trext_e, crc_en_e, match, data_last, crc_last, hunt_last;
    logic [DLEN_W-1:0]  len_e;

    // Effective configuration: live inputs on the very first bit, latched copy afterwards.
    always_comb begin
        m_e      = cfg_vld_q ? m_q      : bus.m;
        trext_e  = cfg_vld_q ? trext_q  : bus.trext;
        crc_en_e = cfg_vld_q ? crc_en_q : bus.en_crc16_for_rpy;
        len_e    = cfg_vld_q ? len_q    : bus.data_len;
    end

    // Next window, serial CRC step and terminal-count decodes.
    always_comb begin
        sr_d      = {sr_q, bus.rx_bit};
        crc_d     = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ bus.rx_bit) ? 16'h1021 : 16'h0000);
        cnt_d     = cnt_q + CNT_W'(1);
        data_last = (cnt_d == {1'b0, len_e});
        crc_last  = (cnt_d == ({1'b0, len_e} + CNT_W'(16)));
        hunt_last = (hunt_cnt_q == HUNT_W'(MAX_HUNT - 1));
    end

    // Preamble compare; the count gate ensures all L pattern bits were actually received.
    always_comb begin
        match = 1'b0;
        if (m_e == 2'b00) begin
            if (trext_e) match = (sr_d[17:0] == 18'h00029) && (hunt_cnt_q >= HUNT_W'(17));
            else         match = (sr_d[5:0]  == 6'b101001) && (hunt_cnt_q >= HUNT_W'(5));
        end else begin
            if (trext_e) match = (sr_d[21:0] == 22'h000017) && (hunt_cnt_q >= HUNT_W'(21));
            else         match = (sr_d[9:0]  == 10'b0000010111) && (hunt_cnt_q >= HUNT_W'(9));
        end
    end

    // Frame FSM with registered outputs; everything advances only on rx_valid.
    always_ff @(posedge clk_frm or negedge rst_for_new_package) begin
        if (!rst_for_new_package) begin
            state_q          <= S_HUNT;
            sr_q             <= '0;
            crc_q            <= 16'hFFFF;
            hunt_cnt_q       <= '0;
            cnt_q            <= '0;
            cfg_vld_q        <= 1'b0;
            m_q              <= 2'b00;
            trext_q          <= 1'b0;
            crc_en_q         <= 1'b0;
            len_q            <= '0;
            preamble_found_q <= 1'b0;
            data_bit_q       <= 1'b0;
            data_valid_q     <= 1'b0;
            frm_complete_q   <= 1'b0;
            crc_ok_q         <= 1'b0;
            crc_err_q        <= 1'b0;
            eos_err_q        <= 1'b0;
            hunt_timeout_q   <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            preamble_found_q <= 1'b0;
            data_valid_q     <= 1'b0;
            busy_q           <= (state_q != S_DONE);
            if (bus.rx_valid) begin
                if (!cfg_vld_q) begin
                    cfg_vld_q <= 1'b1;
                    m_q       <= bus.m;
                    trext_q   <= bus.trext;
                    crc_en_q  <= bus.en_crc16_for_rpy;
                    len_q     <= bus.data_len;
                end
                case (state_q)
                    S_HUNT: begin
                        sr_q       <= sr_d[20:0];
                        hunt_cnt_q <= hunt_cnt_q + HUNT_W'(1);
                        if (match) begin
                            preamble_found_q <= 1'b1;
                            if (len_e != '0) state_q <= S_DATA;
                            else             state_q <= crc_en_e ? S_CRC : S_EOS;
                        end else if (hunt_last) begin
                            hunt_timeout_q <= 1'b1;
                            frm_complete_q <= 1'b1;
                            busy_q         <= 1'b0;
                            state_q        <= S_DONE;
                        end
                    end
                    S_DATA: begin
                        data_bit_q   <= bus.rx_bit;
                        data_valid_q <= 1'b1;
                        crc_q        <= crc_d;
                        cnt_q        <= cnt_d;
                        if (data_last) state_q <= crc_en_e ? S_CRC : S_EOS;
                    end
                    S_CRC: begin
                        crc_q <= crc_d;
                        cnt_q <= cnt_d;
                        if (crc_last) state_q <= S_EOS;
                    end
                    S_EOS: begin
                        eos_err_q      <= ~bus.rx_bit;
                        frm_complete_q <= 1'b1;
                        if (crc_en_e) begin
                            crc_ok_q  <= (crc_q == 16'h1D0F);
                            crc_err_q <= (crc_q != 16'h1D0F);
                        end
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                    S_DONE:  state_q <= S_DONE;
                    default: state_q <= S_HUNT;
                endcase
            end
        end
    end

    assign bus.preamble_found = preamble_found_q;
    assign bus.data_bit       = data_bit_q;
    assign bus.data_valid     = data_valid_q;
    assign bus.frm_complete   = frm_complete_q;
    assign bus.crc_ok         = crc_ok_q;
    assign bus.crc_err        = crc_err_q;
    assign bus.eos_err        = eos_err_q;
    assign bus.hunt_timeout   = hunt_timeout_q;
    assign bus.busy           = busy_q;
    assign state_o            = state_q;
endmodule

// File: tb/tb_frm_parser.sv
// Testbench for frm_parser: directed frames followed by randomized frames, each predicted by a
// stream-level reference model (preamble search over the sent bit list, CRC over the data list).
module tb_frm_parser;
    logic       clk_frm = 1'b0;
    logic       rst_for_new_package;
    logic [2:0] state_dbg;

    frm_if #(.DLEN_W(8)) bus ();

    frm_parser #(.MAX_HUNT(64), .DLEN_W(8)) dut (
        .clk_frm             (clk_frm),
        .rst_for_new_package (rst_for_new_package),
        .bus                 (bus),
        .state_o             (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk_frm = ~clk_frm;

    int checks = 0;
    int errors = 0;

    bit         stim_q[$];
    bit         data_q[$];
    logic [0:0] exp_q[$];
    logic [0:0] got_q[$];
    int         pf_cnt = 0;

    logic [1:0] cfg_m;
    logic       cfg_trext, cfg_crc;
    logic [7:0] cfg_len;

    int exp_pf, exp_done, exp_ok, exp_err, exp_eos, exp_to;

    // ---------------- monitor ----------------
    always @(negedge clk_frm) begin
        if (bus.data_valid === 1'b1) got_q.push_back(bus.data_bit);
        if (bus.preamble_found === 1'b1) pf_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_cfg(input logic [1:0] m, input logic t, input logic c, input logic [7:0] len);
        cfg_m = m; cfg_trext = t; cfg_crc = c; cfg_len = len;
        bus.m = m; bus.trext = t; bus.en_crc16_for_rpy = c; bus.data_len = len;
    endtask

    task automatic reset_assert();
        bus.rx_valid = 1'b0;
        bus.rx_bit   = 1'b0;
        rst_for_new_package = 1'b0;
        repeat (2) @(negedge clk_frm);
        got_q.delete();
        pf_cnt = 0;
    endtask

    task automatic reset_release();
        rst_for_new_package = 1'b1;
    endtask

    task automatic send_bit(input bit b, input bit gaps);
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                bus.rx_bit = 1'($urandom);
                @(negedge clk_frm);
            end
        end
        bus.rx_bit   = b;
        bus.rx_valid = 1'b1;
        @(negedge clk_frm);
        bus.rx_valid = 1'b0;
    endtask

    // Sends stim_q; optionally scrambles the config inputs after the first bit has been taken.
    task automatic send_stream(input bit gaps, input bit scramble);
        for (int i = 0; i < stim_q.size(); i++) begin
            send_bit(stim_q[i], gaps);
            if (scramble && i == 0) begin
                bus.m = 2'($urandom); bus.trext = 1'($urandom);
                bus.en_crc16_for_rpy = 1'($urandom); bus.data_len = 8'($urandom);
            end
        end
        repeat (3) @(negedge clk_frm);
    endtask

    // ---------------- stream builders ----------------
    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stim_q.push_back(v[i]);
    endtask

    task automatic push_data(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            stim_q.push_back(v[i]);
            data_q.push_back(v[i]);
        end
    endtask

    task automatic get_preamble(input logic [1:0] m, input logic t, output bit pre[$]);
        logic [5:0] tail;
        int zeros;
        pre.delete();
        if (m == 2'b00) begin zeros = t ? 12 : 0;  tail = 6'b101001; end
        else            begin zeros = t ? 16 : 4;  tail = 6'b010111; end
        for (int i = 0; i < zeros; i++) pre.push_back(1'b0);
        for (int i = 5; i >= 0; i--) pre.push_back(tail[i]);
    endtask

    task automatic push_preamble(input logic [1:0] m, input logic t);
        bit pre[$];
        get_preamble(m, t, pre);
        foreach (pre[i]) stim_q.push_back(pre[i]);
    endtask

    function automatic logic [15:0] crc16_ref(input bit d[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (d[i]) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    // ---------------- reference model ----------------
    task automatic model();
        bit pre[$];
        bit dbits[$];
        int match = -1;
        int p;
        logic [15:0] rx_crc;
        exp_pf = 0; exp_done = 0; exp_ok = 0; exp_err = 0; exp_eos = 0; exp_to = 0;
        exp_q.delete();
        get_preamble(cfg_m, cfg_trext, pre);
        for (int i = 0; i < stim_q.size() && i < 64; i++) begin
            if (i + 1 >= pre.size()) begin
                bit ok = 1'b1;
                for (int k = 0; k < pre.size(); k++)
                    if (stim_q[i - pre.size() + 1 + k] != pre[k]) ok = 1'b0;
                if (ok) begin match = i; break; end
            end
        end
        if (match < 0) begin
            if (stim_q.size() >= 64) begin exp_to = 1; exp_done = 1; end
        end else begin
            exp_pf = 1;
            p = match + 1;
            for (int k = 0; k < cfg_len && p < stim_q.size(); k++, p++) begin
                exp_q.push_back(stim_q[p]);
                dbits.push_back(stim_q[p]);
            end
            rx_crc = '0;
            if (cfg_crc)
                for (int k = 0; k < 16 && p < stim_q.size(); k++, p++) rx_crc = {rx_crc[14:0], stim_q[p]};
            if (dbits.size() == cfg_len && p < stim_q.size()) begin
                exp_done = 1;
                exp_eos  = (stim_q[p] == 1'b0);
                if (cfg_crc) begin
                    exp_ok  = (rx_crc == ~crc16_ref(dbits));
                    exp_err = !exp_ok;
                end
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_frame(input string name);
        model();
        chk({name, ":preamble_cnt"}, pf_cnt, exp_pf);
        chk({name, ":frm_complete"}, bus.frm_complete, exp_done[0]);
        chk({name, ":crc_ok"}, bus.crc_ok, exp_ok[0]);
        chk({name, ":crc_err"}, bus.crc_err, exp_err[0]);
        chk({name, ":eos_err"}, bus.eos_err, exp_eos[0]);
        chk({name, ":hunt_timeout"}, bus.hunt_timeout, exp_to[0]);
        chk({name, ":busy"}, bus.busy, !exp_done[0]);
        chk({name, ":n_data"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s:data[%0d]", name, i), got_q[i], exp_q[i]);
    endtask

    task automatic build_test1();
        stim_q.delete(); data_q.delete();
        push_bits(6'b101001, 6);
        push_data(8'hA5, 8);
        push_bits(1, 1);
    endtask

    task automatic build_test2(input bit flip);
        string s = "123456789";
        stim_q.delete(); data_q.delete();
        push_preamble(2'b10, 1'b1);
        for (int i = 0; i < s.len(); i++) push_data(32'(s[i]), 8);
        push_bits(16'hD64E, 16);
        push_bits(1, 1);
        if (flip) begin
            stim_q[22 + 5] = ~stim_q[22 + 5];
            data_q[5]      = ~data_q[5];
        end
    endtask

    // ---------------- directed then random sequence ----------------
    initial begin
        set_cfg(2'b00, 1'b0, 1'b0, 8'd8);
        reset_assert();
        chk("reset:busy", bus.busy, 1'b0);
        chk("reset:frm_complete", bus.frm_complete, 1'b0);
        chk("reset:data_valid", bus.data_valid, 1'b0);
        chk("reset:preamble_found", bus.preamble_found, 1'b0);
        chk("reset:flags", {bus.crc_ok, bus.crc_err, bus.eos_err, bus.hunt_timeout}, 4'b0000);
        chk("reset:state", state_dbg, 3'd0);

        // 1: FM0, no trext, CRC off, len 8, with pulse timing
        build_test1();
        reset_release();
        for (int i = 0; i < stim_q.size(); i++) begin
            send_bit(stim_q[i], 1'b0);
            if (i == 0) chk("t1:busy_hunt", bus.busy, 1'b1);
            if (i == 4) chk("t1:pf_early", bus.preamble_found, 1'b0);
            if (i == 5) chk("t1:pf_pulse", bus.preamble_found, 1'b1);
            if (i == 6) chk("t1:first_dv", {bus.data_valid, bus.data_bit}, 2'b11);
        end
        repeat (3) @(negedge clk_frm);
        check_frame("t1");

        // 2: Miller M=4, trext, CRC on, "123456789" with its CRC
        set_cfg(2'b10, 1'b1, 1'b1, 8'd72);
        reset_assert(); build_test2(1'b0); reset_release();
        send_stream(1'b0, 1'b0);
        check_frame("t2");
        chk("t2:crc_ok_const", bus.crc_ok, 1'b1);
        chk("t2:n72", got_q.size(), 72);

        // 3: same with data bit 5 flipped
        reset_assert(); build_test2(1'b1); reset_release();
        send_stream(1'b0, 1'b0);
        check_frame("t3");
        chk("t3:crc_err_const", bus.crc_err, 1'b1);

        // 4: bad end-of-signalling bit
        set_cfg(2'b00, 1'b0, 1'b0, 8'd4);
        reset_assert();
        stim_q.delete(); data_q.delete();
        push_bits(6'b101001, 6); push_data(4'b1100, 4); push_bits(0, 1);
        reset_release();
        send_stream(1'b0, 1'b0);
        check_frame("t4");
        chk("t4:eos_err_const", bus.eos_err, 1'b1);

        // 5: no preamble within 64 bits; trailing preamble after DONE must be ignored
        reset_assert();
        stim_q.delete(); data_q.delete();
        for (int i = 0; i < 32; i++) push_bits(2'b10, 2);
        push_bits(10'b1010010101, 10);
        reset_release();
        send_stream(1'b0, 1'b0);
        check_frame("t5");
        chk("t5:timeout_const", bus.hunt_timeout, 1'b1);

        // 6: reset after 3 data bits, then a full frame with idle gaps and scrambled config
        set_cfg(2'b00, 1'b0, 1'b0, 8'd8);
        reset_assert(); build_test1(); reset_release();
        for (int i = 0; i < 9; i++) send_bit(stim_q[i], 1'b0);
        #2 rst_for_new_package = 1'b0;
        #1 chk("t6:async_clear", {bus.data_valid, bus.busy, bus.frm_complete}, 3'b000);
        reset_assert();
        reset_release();
        send_stream(1'b1, 1'b1);
        check_frame("t6");
        chk("t6:n8", got_q.size(), 8);

        // random frames
        for (int f = 0; f < 12; f++) begin
            logic [15:0] crc_tx;
            set_cfg(2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 40)));
            reset_assert();
            stim_q.delete(); data_q.delete();
            if ($urandom_range(0, 5) == 0) begin
                for (int i = 0; i < 70; i++) push_bits(1'($urandom), 1);
            end else begin
                repeat ($urandom_range(0, 6)) push_bits(1'($urandom), 1);
                push_preamble(cfg_m, cfg_trext);
                for (int i = 0; i < cfg_len; i++) push_data(1'($urandom), 1);
                crc_tx = ~crc16_ref(data_q);
                if ($urandom_range(0, 3) == 0) crc_tx ^= 16'(1 << $urandom_range(0, 15));
                if (cfg_crc) push_bits(crc_tx, 16);
                push_bits(($urandom_range(0, 3) != 0), 1);
            end
            reset_release();
            send_stream(1'($urandom), 1'($urandom));
            check_frame($sformatf("rnd%0d", f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
